// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared constants, select type and slice helpers for demux_fifo_1_4
package demux_pkg;

    localparam int NCH   = 4;
    localparam int SEL_W = 2;

    typedef logic [SEL_W-1:0] sel_t;

    // LSB of channel ch inside the packed out_data bus
    function automatic int data_lsb(input int ch, input int width);
        return ch * width;
    endfunction

    // LSB of channel ch inside the packed out_count bus (AW+1 bits per channel)
    function automatic int count_lsb(input int ch, input int aw);
        return ch * (aw + 1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock show-ahead FIFO
//  clk, rst      clock, asynchronous active-high reset
//  push, din     write strobe and word (ignored while full)
//  pop           read strobe (ignored while empty)
//  dout          head-of-FIFO word, valid while empty=0
//  empty, full   status flags derived from the registered count
//  count         occupancy 0..DEPTH
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            // Simultaneous push and pop leave the occupancy unchanged
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    // Show-ahead: the head word is presented without a read request
    assign dout  = mem[rd_ptr];

endmodule

// File: rtl/demux_fifo_1_4.sv
// rtl/demux_fifo_1_4.sv - buffered 1:4 stream distributor with per-channel FIFOs
//  clk, rst    clock, asynchronous active-high reset
//  in_valid    input word present
//  in_sel      destination channel 0..3
//  in_data     input word
//  in_ready    destination channel not full
//  out_valid   per-channel head word present
//  out_ready   per-channel consumer ready
//  out_data    channel i at [i*WIDTH +: WIDTH]
//  out_count   channel i occupancy at [i*(AW+1) +: AW+1]
module demux_fifo_1_4
    import demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  sel_t                  in_sel,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  in_ready,
    output logic [NCH-1:0]        out_valid,
    input  logic [NCH-1:0]        out_ready,
    output logic [NCH*WIDTH-1:0]  out_data,
    output logic [NCH*(AW+1)-1:0] out_count
);

    logic [NCH-1:0] full;
    logic [NCH-1:0] empty;
    logic [NCH-1:0] push;

    // Depends only on in_sel and registered full flags; a channel popping in
    // the same cycle does not open the gate (no look-ahead).
    assign in_ready = ~full[in_sel];

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic pop;

        assign push[i]      = in_valid & in_ready & (in_sel == sel_t'(i));
        assign pop          = out_valid[i] & out_ready[i];
        assign out_valid[i] = ~empty[i];

        sync_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH),
            .AW    (AW)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[i]),
            .din   (in_data),
            .pop   (pop),
            .dout  (out_data[data_lsb(i, WIDTH) +: WIDTH]),
            .empty (empty[i]),
            .full  (full[i]),
            .count (out_count[count_lsb(i, AW) +: AW+1])
        );
    end

endmodule

// File: tb/tb_demux_fifo_1_4.sv
// tb/tb_demux_fifo_1_4.sv - self-checking bench for demux_fifo_1_4
module tb_demux_fifo_1_4;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [1:0]  in_sel;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data;
    logic [11:0] out_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       v;
        logic [1:0] sel;
        logic [7:0] d;
        logic [3:0] ordy;
        logic       ir;
        logic [3:0] ov;
        logic [11:0] cnt;
        logic [1:0] ch;
        logic [7:0] head;
    } vec_t;

    vec_t vq[$];
    logic [7:0] mq[4][$];

    demux_fifo_1_4 #(.WIDTH(8), .DEPTH(4), .AW(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish (total=%0d bad=%0d)", total, bad);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic v, input logic [1:0] sel, input logic [7:0] d,
                       input logic [3:0] ordy, input logic ir, input logic [3:0] ov,
                       input logic [11:0] cnt, input logic [1:0] ch, input logic [7:0] head);
        vec_t t;
        t.v = v; t.sel = sel; t.d = d; t.ordy = ordy; t.ir = ir;
        t.ov = ov; t.cnt = cnt; t.ch = ch; t.head = head;
        vq.push_back(t);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_data = 8'h00; out_ready = 4'b0;

        // Vector columns: valid sel data out_ready | in_ready out_valid out_count head_ch head
        // Expectations describe the state seen before the clock edge that applies the inputs.
        // Single route to ch1, then pop
        add(1, 1, 8'hA5, 4'b0000, 1, 4'b0000, 12'h000, 0, 8'h00);
        add(0, 0, 8'h00, 4'b0010, 1, 4'b0010, 12'h008, 1, 8'hA5);
        add(0, 0, 8'h00, 4'b0000, 1, 4'b0000, 12'h000, 0, 8'h00);
        // Fill ch3, 5th word held back, then drain in order and accept it
        add(1, 3, 8'h11, 4'b0000, 1, 4'b0000, 12'h000, 0, 8'h00);
        add(1, 3, 8'h22, 4'b0000, 1, 4'b1000, 12'h200, 3, 8'h11);
        add(1, 3, 8'h33, 4'b0000, 1, 4'b1000, 12'h400, 3, 8'h11);
        add(1, 3, 8'h44, 4'b0000, 1, 4'b1000, 12'h600, 3, 8'h11);
        add(1, 3, 8'h55, 4'b0000, 0, 4'b1000, 12'h800, 3, 8'h11);
        add(1, 3, 8'h55, 4'b1000, 0, 4'b1000, 12'h800, 3, 8'h11);
        add(1, 3, 8'h55, 4'b1000, 1, 4'b1000, 12'h600, 3, 8'h22);
        add(0, 0, 8'h00, 4'b1000, 1, 4'b1000, 12'h600, 3, 8'h33);
        add(0, 0, 8'h00, 4'b1000, 1, 4'b1000, 12'h400, 3, 8'h44);
        add(0, 0, 8'h00, 4'b1000, 1, 4'b1000, 12'h200, 3, 8'h55);
        add(0, 0, 8'h00, 4'b0000, 1, 4'b0000, 12'h000, 0, 8'h00);
        // Independence: ch1 full and stalled, ch0/ch2 still accept
        add(1, 1, 8'h61, 4'b0000, 1, 4'b0000, 12'h000, 0, 8'h00);
        add(1, 1, 8'h62, 4'b0000, 1, 4'b0010, 12'h008, 1, 8'h61);
        add(1, 1, 8'h63, 4'b0000, 1, 4'b0010, 12'h010, 1, 8'h61);
        add(1, 1, 8'h64, 4'b0000, 1, 4'b0010, 12'h018, 1, 8'h61);
        add(1, 0, 8'h70, 4'b0000, 1, 4'b0010, 12'h020, 1, 8'h61);
        add(1, 2, 8'h80, 4'b0000, 1, 4'b0011, 12'h021, 0, 8'h70);
        add(1, 1, 8'h99, 4'b0000, 0, 4'b0111, 12'h061, 2, 8'h80);
        add(0, 0, 8'h00, 4'b0010, 1, 4'b0111, 12'h061, 1, 8'h61);
        add(0, 0, 8'h00, 4'b0111, 1, 4'b0111, 12'h059, 1, 8'h62);
        add(0, 0, 8'h00, 4'b0010, 1, 4'b0010, 12'h010, 1, 8'h63);
        add(0, 0, 8'h00, 4'b0010, 1, 4'b0010, 12'h008, 1, 8'h64);
        add(0, 0, 8'h00, 4'b0000, 1, 4'b0000, 12'h000, 0, 8'h00);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'h0);
        chk("reset_out_count", 32'(out_count), 32'h0);
        chk("reset_out_data", out_data, 32'h0);
        chk("reset_in_ready", 32'(in_ready), 32'h1);
        rst = 1'b0;

        // Table-driven vectors
        foreach (vq[k]) begin
            in_valid  = vq[k].v;
            in_sel    = vq[k].sel;
            in_data   = vq[k].d;
            out_ready = vq[k].ordy;
            @(negedge clk);
            chk($sformatf("vec%0d_in_ready", k), 32'(in_ready), 32'(vq[k].ir));
            chk($sformatf("vec%0d_out_valid", k), 32'(out_valid), 32'(vq[k].ov));
            chk($sformatf("vec%0d_out_count", k), 32'(out_count), 32'(vq[k].cnt));
            if (vq[k].ov[vq[k].ch])
                chk($sformatf("vec%0d_head", k), 32'(out_data[vq[k].ch*8 +: 8]), 32'(vq[k].head));
            @(posedge clk);
            #1;
        end

        // Asynchronous reset mid-stream with 3 words queued on ch2
        out_ready = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_sel = 2'd2; in_data = 8'hC0 + 8'(k);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre_reset_count", 32'(out_count), 32'h0C0);
        in_valid = 1'b1; in_sel = 2'd2; in_data = 8'hEE;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'h0);
        chk("midrst_out_count", 32'(out_count), 32'h0);
        chk("midrst_in_ready", 32'(in_ready), 32'h1);
        chk("midrst_out_data", out_data, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("postrst_out_valid", 32'(out_valid), 32'h0);

        // Pointer wrap on ch0 with simultaneous push/pop
        @(posedge clk);
        #1;
        out_ready = 4'b0001;
        for (int k = 0; k <= 10; k++) begin
            in_valid = (k < 10);
            in_sel   = 2'd0;
            in_data  = 8'h30 + 8'(k);
            @(negedge clk);
            if (k == 0) begin
                chk("wrap_start_count", 32'(out_count[2:0]), 32'h0);
            end else begin
                chk($sformatf("wrap%0d_valid", k), 32'(out_valid[0]), 32'h1);
                chk($sformatf("wrap%0d_count", k), 32'(out_count[2:0]), 32'h1);
                chk($sformatf("wrap%0d_head", k), 32'(out_data[7:0]), 32'(8'h30 + 8'(k - 1)));
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("wrap_end_count", 32'(out_count), 32'h0);
        @(posedge clk);
        #1;

        // Random traffic against a per-channel queue model
        for (int c = 0; c < 2000; c++) begin
            in_valid  = ($urandom_range(0, 9) < 8);
            in_sel    = 2'($urandom_range(0, 3));
            in_data   = 8'($urandom);
            out_ready = 4'($urandom) & 4'($urandom | 32'h5);
            @(negedge clk);
            chk("rnd_in_ready", 32'(in_ready), 32'(mq[in_sel].size() < 4));
            for (int i = 0; i < 4; i++) begin
                chk("rnd_valid", 32'(out_valid[i]), 32'(mq[i].size() > 0));
                chk("rnd_count", 32'(out_count[i*3 +: 3]), 32'(mq[i].size()));
                if (mq[i].size() > 0)
                    chk("rnd_data", 32'(out_data[i*8 +: 8]), 32'(mq[i][0]));
            end
            begin
                logic acc;
                acc = in_valid && (mq[in_sel].size() < 4);
                for (int i = 0; i < 4; i++) begin
                    if (mq[i].size() > 0 && out_ready[i])
                        void'(mq[i].pop_front());
                end
                if (acc)
                    mq[in_sel].push_back(in_data);
            end
            @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
